// File: rtl/spio_serial_gen.sv
// spio_serial_gen: CPU-written GPIO/LED/counter_set port with a serialiser
// that shifts the LED image into an external shift-register chain.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, p_data     write strobe and {gpio, led, counter_set} data word
//   start             explicit refresh request (level sampled)
//   counter_set       latched counter_set field
//   led_out           latched LED field
//   gpio_out          latched GPIO field
//   led_clk           serial clock, idle low, receiver samples on rise
//   led_sout          serial data
//   led_clrn          chain clear, active low
//   led_pen           chain output enable, low while shifting
//   busy, done        frame in progress / one-cycle end-of-frame pulse
//
// Optional feature: define SPIO_BLINK_EN to make the top GPIO bit a blink
// enable that blanks the lit LEDs every other blink phase.
module spio_serial_gen #(
    parameter int              DATA_W    = 32,
    parameter int              LED_W     = 16,
    parameter int              CS_W      = 2,
    parameter int              CLK_DIV   = 2,
    parameter logic [LED_W-1:0] LED_RST  = 16'h002A,
    parameter int              BLINK_DIV = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             p_data,
    input  logic                          start,
    output logic [CS_W-1:0]               counter_set,
    output logic [LED_W-1:0]              led_out,
    output logic [DATA_W-LED_W-CS_W-1:0]  gpio_out,
    output logic                          led_clk,
    output logic                          led_sout,
    output logic                          led_clrn,
    output logic                          led_pen,
    output logic                          busy,
    output logic                          done
);
    localparam int GPIO_W = DATA_W - LED_W - CS_W;
    localparam int BW     = $clog2(LED_W + 1);
    localparam int DW     = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    state_t            state, next_state;
    logic              pending;
    logic [LED_W-1:0]  sh;
    logic [LED_W-1:0]  img;
    logic [LED_W-1:0]  led_vis;
    logic [DW-1:0]     div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              phase;
    logic              blink_ev;
    logic              div_end;
    logic              last_bit;
    logic              ev;

`ifdef SPIO_BLINK_EN
    logic [BLINK_DIV-1:0] blink_cnt;
    logic                 blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt)
                blink_phase <= ~blink_phase;
        end
    end

    assign blink_ev = &blink_cnt;
    assign led_vis  = (gpio_out[GPIO_W-1] && !blink_phase) ? '0 : led_out;
`else
    assign blink_ev = 1'b0;
    assign led_vis  = led_out;
`endif

    // Frame image is the bit-reversed, inverted LED image: the chain wants
    // LED[0] first and drives LEDs active-low.
    always_comb begin
        img = '0;
        for (int i = 0; i < LED_W; i++)
            img[i] = ~led_vis[LED_W-1-i];
    end

    assign div_end  = div_cnt == DW'(CLK_DIV - 1);
    assign last_bit = bit_cnt == BW'(LED_W - 1);
    assign ev       = start || (wr_en && p_data[CS_W +: LED_W] != led_out) || blink_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = pending ? LOAD : IDLE;
            LOAD:    next_state = SHIFT;
            SHIFT:   next_state = (phase && div_end && last_bit) ? LATCH : SHIFT;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = state != IDLE;
        done     = state == LATCH;
        led_pen  = !(state == LOAD || state == SHIFT);
        led_clk  = state == SHIFT && phase;
        led_sout = state == SHIFT && sh[LED_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out     <= LED_RST;
            counter_set <= '0;
            gpio_out    <= '0;
            led_clrn    <= 1'b0;
            pending     <= 1'b0;
            sh          <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            phase       <= 1'b0;
        end else begin
            led_clrn <= 1'b1;
            if (wr_en)
                {gpio_out, led_out, counter_set} <= p_data;
            // Leaving IDLE consumes the request; events in the same edge
            // still re-arm it so nothing is lost.
            pending <= ev || (pending && state != IDLE);
            if (state == LOAD) begin
                sh      <= img;
                div_cnt <= '0;
                bit_cnt <= '0;
                phase   <= 1'b0;
            end else if (state == SHIFT) begin
                div_cnt <= div_end ? '0 : div_cnt + 1'b1;
                if (div_end)
                    phase <= ~phase;
                if (div_end && phase) begin
                    sh      <= sh << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spio_serial_gen.sv
// tb_spio_serial_gen: directed bench for spio_serial_gen with a per-cycle model.
module tb_spio_serial_gen;
    localparam int DATA_W = 32;
    localparam int LED_W  = 16;
    localparam int CS_W   = 2;
    localparam int C      = 2;
    localparam int GPIO_W = DATA_W - LED_W - CS_W;
    localparam int FRAME  = 2 + 2 * C * LED_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] p_data = '0;
    logic              start = 1'b0;
    logic [CS_W-1:0]   counter_set;
    logic [LED_W-1:0]  led_out;
    logic [GPIO_W-1:0] gpio_out;
    logic              led_clk, led_sout, led_clrn, led_pen, busy, done;

    int vecs = 0;
    int errs = 0;

    spio_serial_gen dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .p_data(p_data), .start(start),
        .counter_set(counter_set), .led_out(led_out), .gpio_out(gpio_out),
        .led_clk(led_clk), .led_sout(led_sout), .led_clrn(led_clrn),
        .led_pen(led_pen), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // inputs seen by the DUT at each rising edge
    logic              c_wr = 1'b0, c_start = 1'b0, c_ok = 1'b0;
    logic [DATA_W-1:0] c_data = '0;
    always @(posedge clk) begin
        c_wr    <= wr_en;
        c_start <= start;
        c_data  <= p_data;
        c_ok    <= rst_n;
    end

    // model: frame position m_f (-1 = idle, 0 = load, FRAME-1 = latch)
    logic [LED_W-1:0]  m_led = 16'h002A, m_fled = '0;
    logic [GPIO_W-1:0] m_gpio = '0;
    logic [CS_W-1:0]   m_cs = '0;
    logic              m_pend = 1'b0, m_clrn = 1'b0;
    int                m_f = -1;
    int                done_cnt = 0, busy_cnt = 0, rise_cnt = 0;
    logic [15:0]       rx = '0;
    logic              prev_clk = 1'b0;

    always @(negedge clk) begin
        logic ev, in_shift, e_clk, e_sout;
        int k;
        if (!rst_n) begin
            m_led = 16'h002A; m_gpio = '0; m_cs = '0;
            m_pend = 1'b0; m_clrn = 1'b0; m_f = -1;
        end else if (c_ok) begin
            ev = c_start || (c_wr && c_data[CS_W +: LED_W] != m_led);
            if (m_f < 0) begin
                if (m_pend) m_f = 0;
                m_pend = ev;
            end else begin
                if (m_f == 0) m_fled = m_led;
                m_f = (m_f == FRAME - 1) ? -1 : m_f + 1;
                m_pend = m_pend || ev;
            end
            if (c_wr) {m_gpio, m_led, m_cs} = c_data;
            m_clrn = 1'b1;
        end
        in_shift = m_f >= 1 && m_f <= FRAME - 2;
        k        = m_f - 1;
        e_clk    = in_shift && (k % (2 * C)) >= C;
        e_sout   = in_shift && !m_fled[k / (2 * C)];
        chk("busy", busy, m_f >= 0);
        chk("done", done, m_f == FRAME - 1);
        chk("led_pen", led_pen, !(m_f >= 0 && m_f < FRAME - 1));
        chk("led_clk", led_clk, e_clk);
        chk("led_sout", led_sout, e_sout);
        chk("led_clrn", led_clrn, m_clrn);
        chk("led_out", led_out, m_led);
        chk("gpio_out", gpio_out, m_gpio);
        chk("counter_set", counter_set, m_cs);
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (led_clk && !prev_clk) begin
            rise_cnt++;
            rx = {rx[14:0], led_sout};
        end
        prev_clk = led_clk;
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic write(input logic [DATA_W-1:0] d);
        wr_en = 1'b1; p_data = d; cyc(); wr_en = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 400) begin cyc(); n++; end
        if (n >= 400) chk("idle_timeout", busy, 0);
    endtask

    initial begin
        int d0, b0, r0, g;
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0, b0, r0, g;
        cyc(3);
        chk("rst_led_out", led_out, 16'h002A);
        chk("rst_led_pen", led_pen, 1);
        chk("rst_led_clrn", led_clrn, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        chk("clrn_before_edge", led_clrn, 0);
        cyc();
        chk("clrn_after_edge", led_clrn, 1);

        // single start: one frame of LED image 0x002A
        d0 = done_cnt; b0 = busy_cnt; r0 = rise_cnt;
        pulse_start();
        cyc();
        wait_idle();
        cyc(3);
        chk("f1_done", done_cnt - d0, 1);
        chk("f1_busy_len", busy_cnt - b0, 66);
        chk("f1_rises", rise_cnt - r0, 16);
        chk("f1_bits", rx, 16'hABFF);

        // write launches a frame one cycle after the registers update
        d0 = done_cnt;
        write(32'hABCD_1235);
        chk("wr_cs", counter_set, 2'd1);
        chk("wr_led", led_out, 16'h448D);
        chk("wr_gpio", gpio_out, 14'h2AF3);
        chk("wr_busy_now", busy, 0);
        cyc();
        chk("wr_busy_next", busy, 1);
        wait_idle();
        cyc(3);
        chk("wr_bits", rx, 16'h4EDD);
        chk("wr_done", done_cnt - d0, 1);

        // identical LED value written twice -> single frame
        d0 = done_cnt;
        write(32'h0000_0004);
        write(32'h0000_0004);
        cyc();
        wait_idle();
        cyc(10);
        chk("same_led_frames", done_cnt - d0, 1);

        // three starts during a frame coalesce into one extra frame
        d0 = done_cnt;
        pulse_start(); cyc(5);
        pulse_start(); cyc(3);
        pulse_start(); cyc(3);
        pulse_start();
        wait_idle();
        g = 0;
        while (!busy && g < 10) begin cyc(); g++; end
        chk("b2b_gap", g, 1);
        wait_idle();
        cyc(10);
        chk("coalesce_frames", done_cnt - d0, 2);

        // write in flight: frame keeps old image, new value follows
        d0 = done_cnt;
        pulse_start(); cyc(10);
        write(32'h0003_FFFC);
        chk("inflight_led", led_out, 16'hFFFF);
        wait_idle();
        cyc();
        wait_idle();
        cyc(3);
        chk("inflight_frames", done_cnt - d0, 2);
        chk("inflight_bits", rx, 16'h0000);

        // reset during bit 7 aborts immediately, no done pulse
        pulse_start();
        cyc(30);
        chk("pre_rst_busy", busy, 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pen", led_pen, 1);
        chk("mid_rst_clk", led_clk, 0);
        chk("mid_rst_sout", led_sout, 0);
        chk("mid_rst_clrn", led_clrn, 0);
        chk("mid_rst_led", led_out, 16'h002A);
        cyc(2);
        rst_n = 1'b1;
        cyc(100);
        chk("mid_rst_done", done_cnt - d0, 0);
        chk("mid_rst_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
